alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Integer execute unit: single-cycle ALU ops and an iterative shift-add MUL behind valid/ready handshakes.
// Single-cycle ops respond one cycle after accept, MUL after XLEN+1; a result is held until out_ready.
module alu_exec_unit #(
   parameter int XLEN   = 32,
   parameter int MUL_EN = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      Opcode,
   input  logic [2:0]      func3,
   input  logic [6:0]      func7,
   input  logic [1:0]      ALUOp,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);
   localparam int SW = $clog2(XLEN);
   localparam int CW = SW + 1;
   localparam logic [6:0]    OPC_REG   = 7'b0110011;
   localparam logic [6:0]    F7_MULDIV = 7'b0000001;
   localparam logic [CW-1:0] CNT_LAST  = CW'(XLEN - 1);

   typedef enum logic {IDLE, MUL} state_t;

   state_t          state_q, state_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic            illegal_q, illegal_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic [XLEN-1:0] acc_q, acc_d;

   logic            accept;
   logic            dec_mul;
   logic            dec_ill;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] acc_step;
   logic [SW-1:0]   shamt;

   assign shamt     = b[SW-1:0];
   assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : {XLEN{1'b0}});

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

   // Decode and compute; alu_res stays 0 for MUL and illegal encodings
   always_comb begin
      dec_mul = 1'b0;
      dec_ill = 1'b0;
      alu_res = '0;
      case (ALUOp)
         2'b00: alu_res = a + b;
         2'b01: alu_res = a - b;
         2'b10: begin
            if (Opcode == OPC_REG && func7 == F7_MULDIV) begin
               if (func3 == 3'b000 && MUL_EN != 0) begin
                  dec_mul = 1'b1;
               end else begin
                  dec_ill = 1'b1;
               end
            end else begin
               case (func3)
                  3'b000:  alu_res = ({Opcode[5], func7[5]} == 2'b11) ? (a - b) : (a + b);
                  3'b001:  alu_res = a << shamt;
                  3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                  3'b011:  alu_res = {{(XLEN-1){1'b0}}, (a < b)};
                  3'b100:  alu_res = a ^ b;
                  3'b101:  alu_res = func7[5] ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
                  3'b110:  alu_res = a | b;
                  default: alu_res = a & b;
               endcase
            end
         end
         default: dec_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      result_d    = result_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (dec_mul) begin
                  state_d  = MUL;
                  cnt_d    = '0;
                  mcand_d  = a;
                  mplier_d = b;
                  acc_d    = '0;
               end else begin
                  out_valid_d = 1'b1;
                  result_d    = alu_res;
                  zero_d      = (alu_res == '0);
                  illegal_d   = dec_ill;
               end
            end
         end
         MUL: begin
            // One multiplier bit per cycle; only the low XLEN product bits are kept
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d     = IDLE;
               cnt_d       = '0;
               out_valid_d = 1'b1;
               result_d    = acc_step;
               zero_d      = (acc_step == '0);
               illegal_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         cnt_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
      end
   end

endmodule
